// File: rtl/dual_port_memory_pkg.sv
// Shared widths, access-size encodings and response codes for the memory models.
// Also holds the access legality check used by both request ports.
package dual_port_memory_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 3;
  localparam int MEM_CODE_W  = 3;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 3'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 3'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 3'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 3'd4;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID       = 3'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ          = 3'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE         = 3'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED    = 3'd3;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_BOUNDS = 3'd4;

  typedef struct packed {
    logic                  valid;
    logic [MEM_CODE_W-1:0] code;
    logic [WORD_W-1:0]     data;
  } mem_resp_t;

  // Returns the error code for an illegal access, or MEM_CODE_READ when the
  // access may be performed (the caller turns that into WRITE for stores).
  function automatic logic [MEM_CODE_W-1:0] mem_check(
    input logic [MEM_COUNT_W-1:0] count,
    input logic [1:0]             offset,
    input logic                   in_range
  );
    logic misaligned;
    misaligned = 1'b0;
    case (count)
      MEM_COUNT_BYTE: misaligned = 1'b0;
      MEM_COUNT_HALF: misaligned = offset[0];
      MEM_COUNT_WORD: misaligned = (offset != 2'b00);
      default:        return MEM_CODE_INVALID;
    endcase
    if (misaligned) return MEM_CODE_MISALIGNED;
    if (!in_range)  return MEM_CODE_OUT_OF_BOUNDS;
    return MEM_CODE_READ;
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Async-reset delay line for a {valid, code, data} response; STAGES = 0
// collapses to a plain wire.
module mem_resp_pipe
  import dual_port_memory_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STAGES = 0
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  i_valid,
  input  logic [MEM_CODE_W-1:0] i_code,
  input  logic [DATA_W-1:0]     i_data,
  output logic                  o_valid,
  output logic [MEM_CODE_W-1:0] o_code,
  output logic [DATA_W-1:0]     o_data
);

  if (STAGES == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ aresetn;
    assign o_valid = i_valid;
    assign o_code  = i_code;
    assign o_data  = i_data;
  end else begin : g_regs
    localparam int W = 1 + MEM_CODE_W + DATA_W;
    logic [W-1:0] pipe_d [STAGES];
    logic [W-1:0] pipe_q [STAGES];

    always_comb begin
      pipe_d[0] = {i_valid, i_code, i_data};
      for (int i = 1; i < STAGES; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign {o_valid, o_code, o_data} = pipe_q[STAGES-1];
  end

endmodule

// File: rtl/dual_port_memory.sv
// Shared word array behind a read-only instruction port and a read/write data port,
// with a fully pipelined response of LATENCY edges per port.
module dual_port_memory
  import dual_port_memory_pkg::*;
#(
  parameter int WORD_COUNT = 1024,
  parameter int LATENCY    = 1
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic [ADDR_W-1:0]      i_ip_addr,
  input  logic [MEM_COUNT_W-1:0] i_ip_count,
  output logic [WORD_W-1:0]      o_ip_rd_data,
  output logic [MEM_CODE_W-1:0]  o_ip_code,
  output logic                   o_ip_valid,
  input  logic [ADDR_W-1:0]      i_dp_addr,
  input  logic [WORD_W-1:0]      i_dp_wr_data,
  input  logic                   i_dp_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_dp_count,
  input  logic                   i_dp_signed,
  output logic [WORD_W-1:0]      o_dp_rd_data,
  output logic [MEM_CODE_W-1:0]  o_dp_code,
  output logic                   o_dp_valid
);

  // Handshake: a request is any cycle with count != NONE and is always accepted
  // (no ready); o_*_valid pulses once per request, LATENCY edges later, in order.

  localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(WORD_COUNT);

  function automatic logic [WORD_W-1:0] load_lane(
    input logic [WORD_W-1:0]      word,
    input logic [MEM_COUNT_W-1:0] count,
    input logic [1:0]             offset,
    input logic                   sign_ext
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    case (count)
      MEM_COUNT_BYTE: return {{24{sign_ext & b[7]}}, b};
      MEM_COUNT_HALF: return {{16{sign_ext & h[15]}}, h};
      default:        return word;
    endcase
  endfunction

  logic [WORD_W-1:0] mem_q [WORD_COUNT];

  logic [IDX_W-1:0]      ip_idx, dp_idx;
  logic [WORD_W-1:0]     ip_word, dp_word, wr_word_d;
  logic [MEM_CODE_W-1:0] ip_chk, dp_chk;
  logic                  dp_wr;
  mem_resp_t             ip_resp_d, ip_resp_q, dp_resp_d, dp_resp_q;

  assign ip_idx  = i_ip_addr[IDX_W+1:2];
  assign dp_idx  = i_dp_addr[IDX_W+1:2];
  assign ip_word = mem_q[ip_idx];
  assign dp_word = mem_q[dp_idx];
  assign ip_chk  = mem_check(i_ip_count, i_ip_addr[1:0], i_ip_addr[ADDR_W-1:2] < WORD_LIMIT);
  assign dp_chk  = mem_check(i_dp_count, i_dp_addr[1:0], i_dp_addr[ADDR_W-1:2] < WORD_LIMIT);

  always_comb begin
    ip_resp_d = '0;
    if (i_ip_count != MEM_COUNT_NONE) begin
      ip_resp_d.valid = 1'b1;
      ip_resp_d.code  = ip_chk;
      if (ip_chk == MEM_CODE_READ)
        ip_resp_d.data = load_lane(ip_word, i_ip_count, i_ip_addr[1:0], 1'b0);
    end
  end

  always_comb begin
    dp_resp_d = '0;
    dp_wr     = 1'b0;
    wr_word_d = dp_word;
    if (i_dp_count != MEM_COUNT_NONE) begin
      dp_resp_d.valid = 1'b1;
      dp_resp_d.code  = dp_chk;
      if (dp_chk == MEM_CODE_READ) begin
        if (i_dp_wr_en) begin
          dp_wr           = 1'b1;
          dp_resp_d.code  = MEM_CODE_WRITE;
        end else begin
          dp_resp_d.data  = load_lane(dp_word, i_dp_count, i_dp_addr[1:0], i_dp_signed);
        end
      end
    end
    // Merge the store into the current word so untouched lanes are preserved.
    case (i_dp_count)
      MEM_COUNT_BYTE: wr_word_d[{i_dp_addr[1:0], 3'b000} +: 8] = i_dp_wr_data[7:0];
      MEM_COUNT_HALF: wr_word_d[{i_dp_addr[1], 4'b0000} +: 16] = i_dp_wr_data[15:0];
      default:        wr_word_d = i_dp_wr_data;
    endcase
  end

  // Reads above use mem_q before this edge's store lands.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < WORD_COUNT; i++) mem_q[i] <= '0;
    end else if (dp_wr) begin
      mem_q[dp_idx] <= wr_word_d;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ip_resp_q <= '0;
      dp_resp_q <= '0;
    end else begin
      ip_resp_q <= ip_resp_d;
      dp_resp_q <= dp_resp_d;
    end
  end

  mem_resp_pipe #(.DATA_W(WORD_W), .STAGES(LATENCY-1)) u_ip_pipe (
    .clk     (clk),
    .aresetn (aresetn),
    .i_valid (ip_resp_q.valid),
    .i_code  (ip_resp_q.code),
    .i_data  (ip_resp_q.data),
    .o_valid (o_ip_valid),
    .o_code  (o_ip_code),
    .o_data  (o_ip_rd_data)
  );

  mem_resp_pipe #(.DATA_W(WORD_W), .STAGES(LATENCY-1)) u_dp_pipe (
    .clk     (clk),
    .aresetn (aresetn),
    .i_valid (dp_resp_q.valid),
    .i_code  (dp_resp_q.code),
    .i_data  (dp_resp_q.data),
    .o_valid (o_dp_valid),
    .o_code  (o_dp_code),
    .o_data  (o_dp_rd_data)
  );

endmodule

// File: doc/dual_port_memory.md
# dual_port_memory

Simulation memory model with two independent request ports over one shared word array: a read-only instruction port (ip) and a read/write data port (dp). It succeeds the single-port memory model. New features: configurable depth, configurable response latency (fully pipelined), a response-valid strobe, sign-extending sub-word loads, and word-alignment checking. It sits between the fetch/memory pipeline stages and the testbench, and returns the shared `MEM_CODE_*` response codes.

## Interface
- WORD_COUNT, 1024: number of 32-bit words; legal aligned word index range is 0..WORD_COUNT-1.
- LATENCY, 1: edges from request sample to response visible; must be >= 1; LATENCY=1 gives a registered response at the sampling edge.
- clk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- i_ip_addr  in  `ADDR_W  instruction byte address.
- i_ip_count  in  `MEM_COUNT_W  access size; `MEM_COUNT_NONE` means no request.
- o_ip_rd_data  out  `WORD_W  instruction read data, zero-extended.
- o_ip_code  out  `MEM_CODE_W  instruction response code.
- o_ip_valid  out  1  instruction response valid.
- i_dp_addr  in  `ADDR_W  data byte address.
- i_dp_wr_data  in  `WORD_W  store data; the low byte or half is used for sub-word stores.
- i_dp_wr_en  in  1  1 = store, 0 = load.
- i_dp_count  in  `MEM_COUNT_W  access size; `MEM_COUNT_NONE` means no request.
- i_dp_signed  in  1  1 = sign-extend byte/half loads.
- o_dp_rd_data  out  `WORD_W  load data.
- o_dp_code  out  `MEM_CODE_W  data response code.
- o_dp_valid  out  1  data response valid.

## Operation
- Each port is evaluated independently every cycle. Address split: word index = addr[ADDR_W-1:2], byte offset = addr[1:0].
- Check priority for each port with count != NONE, first match wins:
  1. Count not one of BYTE/HALF/WORD: code `MEM_CODE_INVALID`.
  2. Ip port with wr intent: not applicable, the ip port never writes.
  3. Misaligned (HALF with offset[0]=1, or WORD with offset!=0): code `MEM_CODE_MISALIGNED`. This word check is new behaviour.
  4. Word index >= WORD_COUNT: code `MEM_CODE_OUT_OF_BOUNDS`.
  5. Otherwise: the access is performed.
- For every error code: data = 0, valid = 1, no memory update.
- Load: select the byte lane (offset) or half lane (offset[1]) from the addressed word.
  - Data port with i_dp_signed=1 replicates bit 7 (byte) or bit 15 (half) into the upper bits; otherwise zero-fill.
  - Word loads use the aligned word index.
  - Code `MEM_CODE_READ`.
- Store (dp only): update only the addressed byte/half lane or the full word; data = 0; code `MEM_CODE_WRITE`.
- No request (count == NONE): data = 0, code `MEM_CODE_INVALID`, valid = 0.
- Memory is read at the sampling edge. A dp store sampled at edge N is visible to reads on either port sampled at edge N+1 or later. A read sampled at edge N, including the same word on the other port, returns the pre-store contents.

## Timing
- Fully pipelined: one request per port per cycle, no backpressure, responses strictly in request order.
- A request sampled at edge N produces outputs valid after edge N+LATENCY-1. Stage 1 captures the result at edge N; LATENCY-1 further register stages follow.
- Reset (aresetn=0, asynchronous):
  - All memory words cleared to 0.
  - All pipeline stages cleared.
  - o_*_rd_data = 0, o_*_code = 0, o_*_valid = 0.
- Reset asserted mid-operation discards all in-flight responses. Stores already performed at prior edges are also lost, because memory is zeroed.
- Simultaneous events:
  - Both ports reading the same word: both served.
  - An error on one port does not affect the other port.

## Structure
- `MEM_COUNT_*`, `MEM_CODE_*`, and the widths `ADDR_W`, `WORD_W`, `MEM_COUNT_W`, `MEM_CODE_W` come from the shared `config.vh` / `mem_codes.vh`. No new codes are added.
- Sub-module `mem_resp_pipe` (params DATA_W, STAGES): an async-reset delay line for {valid, code, data}. It is instantiated once per port with STAGES = LATENCY-1 and becomes a pass-through when STAGES = 0.
- The lane-select and extend logic is shared between the ports via a function in the top module.

## Test plan
- Reset, then a dp WORD store of 0xDEADBEEF to 0x10 and an ip WORD read of 0x10 one cycle later. Required: dp code WRITE with valid=1; ip returns 0xDEADBEEF with code READ.
- Store byte 0x80 to 0x21, then two dp BYTE loads of 0x21: signed returns 0xFFFFFF80, unsigned returns 0x00000080. Then a HALF load of 0x22 returns 0x0000.
- In the same cycle, a dp store of 0x11111111 to 0x40 and an ip read of 0x40 (prior value 0). Required: ip returns 0x00000000; a repeat ip read of 0x40 next cycle returns 0x11111111.
- Error cases with WORD_COUNT=1024, each returning data=0 and valid=1:
  - dp WORD at 0x2 returns MISALIGNED.
  - dp HALF at 0x1 returns MISALIGNED.
  - ip WORD at 0x1000 returns OUT_OF_BOUNDS.
  - An illegal count encoding returns INVALID, with no memory change.
- With LATENCY=3, back-to-back ip reads of 0x0, 0x4, 0x8 at edges 1, 2, 3. Required: responses appear in order after edges 3, 4, 5 with valid=1; idle cycles give valid=0.
- Assert aresetn with two requests in flight (LATENCY=3). Required: all outputs are 0 immediately; neither response ever appears; memory reads back 0.
